// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-facing bundle of the RV32M multiply/divide unit.
// master: the EX-stage control that issues M-ops and consumes results.
// slave : the multiply/divide unit itself.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [RD_W-1:0] wr_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [RD_W-1:0] wr_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, wr_i, flush_i,
        input  stall_o, busy_o, done_o, result_o, wr_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, wr_i, flush_i,
        output stall_o, busy_o, done_o, result_o, wr_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage.
// Iterative radix-2 shift-add multiply and restoring divide on magnitudes,
// with sign fixup on the last step. State updates on the falling clock edge.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle using a
// 33x33 signed multiplier at acceptance; divides stay iterative.
//
// state | meaning
// IDLE  | waiting for an M-op from ID/EX
// RUN   | one radix-2 step per edge, cnt counts steps 0..31
// DONE  | result_o/wr_o valid, done_o high for one cycle
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q;
    logic [RD_W-1:0]     wr_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opnd_q;
    logic                neg_res_q, neg_rem_q;
    logic [4:0]          cnt_q;

    logic                is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;
    logic                take_fast;
    logic [XLEN-1:0]     fast_res;
    logic                accept;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_r;
    logic                div_ge;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem, fin_res;

    logic                load_res;
    logic [XLEN-1:0]     res_d;
    logic [RD_W-1:0]     wr_d;

    // Operand decode, magnitudes and acceptance-time special cases
    always_comb begin
        is_div   = bus.funct3_i[2];
        a_signed = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
        b_signed = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        sa       = a_signed & bus.op_a_i[XLEN-1];
        sb       = b_signed & bus.op_b_i[XLEN-1];
        a_mag    = sa ? -bus.op_a_i : bus.op_a_i;
        b_mag    = sb ? -bus.op_b_i : bus.op_b_i;
        div_zero = is_div & (bus.op_b_i == '0);
        div_ovf  = is_div & ~bus.funct3_i[0]
                 & (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (bus.op_b_i == {XLEN{1'b1}});
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.op_a_i : {XLEN{1'b1}};
        else
            special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        accept   = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_prod;

    // Single-cycle signed 33x33 product; the extra bit carries signedness
    always_comb begin
        fast_a    = {a_signed & bus.op_a_i[XLEN-1], bus.op_a_i};
        fast_b    = {b_signed & bus.op_b_i[XLEN-1], bus.op_b_i};
        fast_prod = fast_a * fast_b;
        take_fast = ~is_div;
        fast_res  = (bus.funct3_i[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
    end
`else
    // Without the fast multiplier every op takes the iterative path
    always_comb begin
        take_fast = 1'b0;
        fast_res  = '0;
    end
`endif

    // One radix-2 step plus the signed result of the final step
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_r   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge  = (div_r >= {1'b0, opnd_q});
        if (f3_q[2]) begin
            if (div_ge)
                acc_step = {div_r[XLEN-1:0] - opnd_q, acc_q[XLEN-2:0], 1'b1};
            else
                acc_step = {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = neg_res_q ? -acc_step : acc_step;
        quo  = neg_res_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 fin_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_res = quo;
            default:                fin_res = rem;
        endcase
    end

    // Next state and result load; flush overrides everything
    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = '0;
        wr_d     = wr_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    if (special | take_fast) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                        res_d    = special ? special_res : fast_res;
                        wr_d     = bus.wr_i;
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: if (cnt_q == 5'(XLEN-1)) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                    res_d    = fin_res;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q      <= '0;
            wr_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            bus.result_o <= '0;
            bus.wr_o     <= '0;
        end else begin
            if (accept) begin
                f3_q      <= bus.funct3_i;
                wr_q      <= bus.wr_i;
                neg_res_q <= sa ^ sb;
                neg_rem_q <= sa;
                opnd_q    <= is_div ? b_mag : a_mag;
                acc_q     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                cnt_q     <= '0;
            end else if (state_q == RUN && !bus.flush_i) begin
                acc_q <= acc_step;
                cnt_q <= (cnt_q == 5'(XLEN-1)) ? '0 : cnt_q + 5'd1;
            end
            if (load_res) begin
                bus.result_o <= res_d;
                bus.wr_o     <= wr_d;
            end
        end
    end

    // Status outputs; stall is combinational so ID/EX holds on acceptance
    always_comb begin
        bus.busy_o  = (state_q != IDLE);
        bus.done_o  = (state_q == DONE);
        bus.stall_o = (state_q == RUN) | accept;
    end
endmodule
